// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_REQ = 2;

    // Arbiter ownership states: free, or held by one requester via lock.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Requester index (0 or 1).
    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the requester
// that did not win last time is chosen.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] grant
);

    // One-hot grant from request vector and last winner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == req_id_t'(1)) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one synchronous-read data memory.
// Grants are combinational; a lock on a transfer keeps ownership with that
// requester until it transfers unlocked or drops its request. Read data
// returns one cycle after the transfer, steered by a pending flag + owner id.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_0,
    input  logic                  lock_0,
    input  logic                  wen_0,
    input  logic [3:0]            byte_en_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic                  gnt_0,
    output logic                  rvalid_0,
    output logic [DATA_WIDTH-1:0] rdata_0,

    input  logic                  req_1,
    input  logic                  lock_1,
    input  logic                  wen_1,
    input  logic [3:0]            byte_en_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  gnt_1,
    output logic                  rvalid_1,
    output logic [DATA_WIDTH-1:0] rdata_1,

    output logic                  mem_wen,
    output logic [3:0]            mem_byte_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    req_id_t    last_q, last_d;
    logic       pend_q, pend_d;
    req_id_t    pend_id_q, pend_id_d;

    logic [1:0] rr_gnt;
    logic [1:0] gnt;
    logic       xfer;
    req_id_t    gid;
    logic       sel_lock;
    logic       sel_wen;

    rr_pick2 u_rr_pick2 (
        .req   ({req_1, req_0}),
        .last  (last_q),
        .grant (rr_gnt)
    );

    // Grant select: round-robin when free, owner-only when locked.
    // Held low while reset is asserted so nothing reaches memory.
    always_comb begin
        gnt = 2'b00;
        case (state_q)
            IDLE:    gnt = rr_gnt;
            OWN0:    gnt = {1'b0, req_0};
            OWN1:    gnt = {req_1, 1'b0};
            default: gnt = 2'b00;
        endcase
        if (!rst_n) gnt = 2'b00;
    end

    assign gnt_0 = gnt[0];
    assign gnt_1 = gnt[1];
    assign xfer  = |gnt;
    assign gid   = req_id_t'(gnt[1]);

    // Memory-side mux: mirror the granted requester, all zeros otherwise.
    always_comb begin
        mem_wen     = 1'b0;
        mem_byte_en = 4'b0000;
        mem_addr    = '0;
        mem_wdata   = '0;
        sel_lock    = 1'b0;
        sel_wen     = 1'b0;
        if (gnt[0]) begin
            mem_wen     = wen_0;
            mem_byte_en = byte_en_0;
            mem_addr    = addr_0;
            mem_wdata   = wdata_0;
            sel_lock    = lock_0;
            sel_wen     = wen_0;
        end else if (gnt[1]) begin
            mem_wen     = wen_1;
            mem_byte_en = byte_en_1;
            mem_addr    = addr_1;
            mem_wdata   = wdata_1;
            sel_lock    = lock_1;
            sel_wen     = wen_1;
        end
    end

    // Next-state: transfers set ownership and last winner; an owner that
    // stops requesting gives the bus back. Reads arm a one-cycle response.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pend_d    = 1'b0;
        pend_id_d = pend_id_q;
        if (xfer) begin
            last_d    = gid;
            pend_d    = ~sel_wen;
            pend_id_d = gid;
            if (sel_lock) state_d = gid[0] ? OWN1 : OWN0;
            else          state_d = IDLE;
        end else begin
            case (state_q)
                OWN0:    if (!req_0) state_d = IDLE;
                OWN1:    if (!req_1) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, last winner and pending-read registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= req_id_t'(1);
            pend_q    <= 1'b0;
            pend_id_q <= req_id_t'(0);
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
        end
    end

    assign rvalid_0 = pend_q && (pend_id_q == req_id_t'(0));
    assign rvalid_1 = pend_q && (pend_id_q == req_id_t'(1));
    assign rdata_0  = rvalid_0 ? mem_rdata : '0;
    assign rdata_1  = rvalid_1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled memory model.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_0, lock_0, wen_0, gnt_0, rvalid_0;
    logic [3:0]  byte_en_0;
    logic [31:0] addr_0, wdata_0, rdata_0;
    logic        req_1, lock_1, wen_1, gnt_1, rvalid_1;
    logic [3:0]  byte_en_1;
    logic [31:0] addr_1, wdata_1, rdata_1;
    logic        mem_wen;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .lock_0(lock_0), .wen_0(wen_0), .byte_en_0(byte_en_0),
        .addr_0(addr_0), .wdata_0(wdata_0), .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .lock_1(lock_1), .wen_1(wen_1), .byte_en_1(byte_en_1),
        .addr_1(addr_1), .wdata_1(wdata_1), .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .mem_wen(mem_wen), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 16 words indexed by addr[5:2], preloaded on first edge.
    logic [31:0] mem [16];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4]     <= 32'h11112222;
            mem[8]     <= 32'hCAFEF00D;
            mem[12]    <= 32'h33334444;
            mem_loaded <= 1'b1;
            mem_rdata  <= 32'h0;
        end else begin
            if (mem_wen)
                for (int b = 0; b < 4; b++)
                    if (mem_byte_en[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1;
        lock_0 = 1'b0; lock_1 = 1'b0; wen_0 = 1'b1; wen_1 = 1'b1;
        byte_en_0 = 4'h0; byte_en_1 = 4'h0;
        addr_0 = 32'h0; addr_1 = 32'h0; wdata_0 = 32'h0; wdata_1 = 32'h0;
        #2;
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b%b want 00", gnt_1, gnt_0); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen got %b want 0", mem_wen); end
        checks++; if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b want 00", rvalid_1, rvalid_0); end
        @(posedge clk); #1;
        req_0 = 1'b0; req_1 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        req_0 = 1'b1; wen_0 = 1'b0; lock_0 = 1'b0; addr_0 = 32'h10;
        #1;
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL single_gnt got %b%b want 01", gnt_1, gnt_0); end
        checks++; if (mem_addr !== 32'h10 || mem_wen !== 1'b0) begin errors++; $display("FAIL single_mem got addr %h wen %b want 10 0", mem_addr, mem_wen); end
        @(posedge clk); #1;
        req_0 = 1'b0;
        #1;
        checks++; if (rvalid_0 !== 1'b1 || rdata_0 !== 32'h11112222) begin errors++; $display("FAIL single_rvalid got %b %h want 1 11112222", rvalid_0, rdata_0); end
        checks++; if (rvalid_1 !== 1'b0 || rdata_1 !== 32'h0) begin errors++; $display("FAIL single_other got %b %h want 0 0", rvalid_1, rdata_1); end
        @(posedge clk); #2;
        checks++; if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b want 0", rvalid_0); end
    endtask

    task automatic test_round_robin();
        logic exp0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_0 = 1'b1; req_1 = 1'b1; lock_0 = 1'b0; lock_1 = 1'b0;
        wen_0 = 1'b1; wen_1 = 1'b1; byte_en_0 = 4'h0; byte_en_1 = 4'h0;
        addr_0 = 32'h40; addr_1 = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp0 = (k % 2 == 0);
            checks++; if (gnt_0 !== exp0 || gnt_1 !== ~exp0) begin errors++; $display("FAIL rr_gnt[%0d] got %b%b want %b%b", k, gnt_1, gnt_0, ~exp0, exp0); end
            checks++; if (mem_addr !== (exp0 ? 32'h40 : 32'h44) || mem_byte_en !== 4'h0 || mem_wen !== 1'b1) begin
                errors++; $display("FAIL rr_mem[%0d] got addr %h be %h wen %b", k, mem_addr, mem_byte_en, mem_wen); end
            @(posedge clk); #1;
        end
        req_0 = 1'b0; req_1 = 1'b0;
    endtask

    task automatic test_lock();
        req_0 = 1'b1; wen_0 = 1'b1; byte_en_0 = 4'h0; addr_0 = 32'h40;
        req_1 = 1'b1; wen_1 = 1'b1; lock_1 = 1'b0; addr_1 = 32'h44;
        for (int k = 0; k < 3; k++) begin
            lock_0 = (k < 2);
            #1;
            checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL lock_gnt[%0d] got %b%b want 01", k, gnt_1, gnt_0); end
            @(posedge clk); #1;
        end
        req_0 = 1'b0; lock_0 = 1'b0;
        #1;
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0 || mem_addr !== 32'h44) begin
            errors++; $display("FAIL lock_release got gnt %b%b addr %h want 10 44", gnt_1, gnt_0, mem_addr); end
        @(posedge clk); #1;
        req_1 = 1'b0;
    endtask

    task automatic test_abandon();
        req_1 = 1'b1; lock_1 = 1'b1; wen_1 = 1'b1; byte_en_1 = 4'h0;
        #1;
        checks++; if (gnt_1 !== 1'b1) begin errors++; $display("FAIL abandon_enter got %b want 1", gnt_1); end
        @(posedge clk); #1;
        req_1 = 1'b0; lock_1 = 1'b0; req_0 = 1'b1; lock_0 = 1'b0; wen_0 = 1'b1;
        #1;
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin errors++; $display("FAIL abandon_wait got %b%b want 00", gnt_1, gnt_0); end
        checks++; if (mem_wen !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL abandon_mem_idle got wen %b addr %h want 0 0", mem_wen, mem_addr); end
        @(posedge clk); #2;
        checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL abandon_regrant got %b want 1", gnt_0); end
        @(posedge clk); #1;
        req_0 = 1'b0;
    endtask

    task automatic test_write_read();
        req_0 = 1'b1; lock_0 = 1'b0; wen_0 = 1'b1; byte_en_0 = 4'b0011;
        addr_0 = 32'h20; wdata_0 = 32'hDEADBEEF;
        #1;
        checks++; if (gnt_0 !== 1'b1 || mem_wen !== 1'b1 || mem_byte_en !== 4'b0011) begin
            errors++; $display("FAIL wr_ctrl got gnt %b wen %b be %b want 1 1 0011", gnt_0, mem_wen, mem_byte_en); end
        checks++; if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h20) begin
            errors++; $display("FAIL wr_data got %h @%h want deadbeef @20", mem_wdata, mem_addr); end
        @(posedge clk); #1;
        wen_0 = 1'b0; byte_en_0 = 4'h0; wdata_0 = 32'h0;
        #1;
        checks++; if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", rvalid_0); end
        checks++; if (gnt_0 !== 1'b1 || mem_wen !== 1'b0) begin errors++; $display("FAIL rd_ctrl got gnt %b wen %b want 1 0", gnt_0, mem_wen); end
        @(posedge clk); #1;
        req_0 = 1'b0;
        #1;
        checks++; if (rvalid_0 !== 1'b1 || rdata_0 !== 32'hCAFEBEEF) begin
            errors++; $display("FAIL rd_data got %b %h want 1 cafebeef", rvalid_0, rdata_0); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        req_0 = 1'b1; wen_0 = 1'b0; lock_0 = 1'b0; addr_0 = 32'h10;
        req_1 = 1'b1; wen_1 = 1'b0; lock_1 = 1'b0; addr_1 = 32'h30;
        #1;
        checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin errors++; $display("FAIL b2b_first got %b%b want 10", gnt_1, gnt_0); end
        @(posedge clk); #2;
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL b2b_second got %b%b want 01", gnt_1, gnt_0); end
        checks++; if (rvalid_1 !== 1'b1 || rdata_1 !== 32'h33334444) begin errors++; $display("FAIL b2b_rsp1 got %b %h want 1 33334444", rvalid_1, rdata_1); end
        checks++; if (rvalid_0 !== 1'b0 || rdata_0 !== 32'h0) begin errors++; $display("FAIL b2b_quiet0 got %b %h want 0 0", rvalid_0, rdata_0); end
        @(posedge clk); #1;
        req_0 = 1'b0; req_1 = 1'b0;
        #1;
        checks++; if (rvalid_0 !== 1'b1 || rdata_0 !== 32'h11112222) begin errors++; $display("FAIL b2b_rsp0 got %b %h want 1 11112222", rvalid_0, rdata_0); end
        checks++; if (rvalid_1 !== 1'b0 || rdata_1 !== 32'h0) begin errors++; $display("FAIL b2b_quiet1 got %b %h want 0 0", rvalid_1, rdata_1); end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        req_0 = 1'b1; wen_0 = 1'b0; lock_0 = 1'b0; addr_0 = 32'h10;
        #1;
        checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL mid_rd_gnt got %b want 1", gnt_0); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1; wen_0 = 1'b1; wen_1 = 1'b1;
        byte_en_0 = 4'h0; byte_en_1 = 4'h0; lock_1 = 1'b0;
        #1;
        checks++; if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid got %b want 0", rvalid_0); end
        checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0 || mem_wen !== 1'b0) begin
            errors++; $display("FAIL mid_rst_gnt got %b%b wen %b want 00 0", gnt_1, gnt_0, mem_wen); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL post_rst_gnt got %b%b want 01", gnt_1, gnt_0); end
        checks++; if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL post_rst_rvalid got %b want 0", rvalid_0); end
        @(posedge clk); #1;
        req_0 = 1'b0; req_1 = 1'b0;
        #1;
        checks++; if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin errors++; $display("FAIL post_rst_quiet got %b%b want 00", rvalid_1, rvalid_0); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_abandon();
        test_write_read();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of requester and memory address buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of write/read data buses.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have, per requester i in {0,1}, req_i input 1, request valid.
REQ-006 SHALL have, per requester i, lock_i input 1, hold ownership after this transfer.
REQ-007 SHALL have, per requester i, wen_i input 1, 1=write, 0=read.
REQ-008 SHALL have, per requester i, byte_en_i input 4, write byte lanes.
REQ-009 SHALL have, per requester i, addr_i input ADDR_WIDTH, and wdata_i input DATA_WIDTH.
REQ-010 SHALL have, per requester i, gnt_i output 1, transfer accepted this cycle.
REQ-011 SHALL have, per requester i, rvalid_i output 1, and rdata_i output DATA_WIDTH, read response.
REQ-012 SHALL have mem_wen output 1, mem_byte_en output 4, mem_addr output ADDR_WIDTH, mem_wdata output DATA_WIDTH, mem_rdata input DATA_WIDTH (memory has synchronous read, 1-cycle latency).

Function
REQ-013 A transfer for requester i SHALL occur on a rising edge where req_i and gnt_i are both high.
REQ-014 gnt_i SHALL be combinational from req_i and current state; at most one gnt high per cycle; gnt_i never high while req_i low.
REQ-015 FSM states SHALL be IDLE, OWN0, OWN1.
REQ-016 In IDLE, single requester SHALL be granted; both requesting -> grant the requester not in last_grant register (round-robin).
REQ-017 In OWNi, only requester i SHALL be granted; the other waits regardless of its req.
REQ-018 On a transfer with lock_i=1, next state SHALL be OWNi; with lock_i=0 next state SHALL be IDLE.
REQ-019 In OWNi with req_i low, FSM SHALL return to IDLE next cycle (ownership abandoned).
REQ-020 last_grant SHALL update to i on every transfer by i.
REQ-021 While granted, mem_addr, mem_wdata, mem_byte_en SHALL mirror granted requester; mem_wen = wen_i; with no grant all mem outputs SHALL be 0.
REQ-022 Write with byte_en 0 SHALL pass through unchanged (memory no-op), still counted as a transfer.
REQ-023 Read transfer by i SHALL assert rvalid_i for exactly one cycle, the cycle after the transfer, with rdata_i = mem_rdata; writes produce no rvalid.
REQ-024 Back-to-back reads SHALL be supported at one per cycle; rvalid follows each read with 1-cycle latency; rdata_i of non-responding requester SHALL be 0.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state IDLE, last_grant=1, rvalid_0=rvalid_1=0, independent of clk.
REQ-026 A read accepted the edge before reset SHALL not produce rvalid after reset release.
REQ-027 During reset all gnt outputs and mem_wen SHALL be 0.

Structure
REQ-028 Package dmem_arb_pkg SHALL hold the FSM state enum (IDLE, OWN0, OWN1), requester-id typedef, and constant NUM_REQ=2.
REQ-029 Round-robin pick logic SHALL be one sub-module, rr_pick2 (inputs req[1:0], last; output one-hot grant).
REQ-030 Response tracking SHALL be a registered pending-read flag plus owner id, no FIFO.

Verification
REQ-031 Reset release, req_0 read addr 0x10 alone -> gnt_0 same cycle, mem_addr=0x10, rvalid_0 next cycle with rdata_0=mem_rdata.
REQ-032 Both req high from reset, no lock, 4 cycles -> grants 0,1,0,1.
REQ-033 req_0 lock=1 for 3 writes while req_1 high -> gnt_1 stays 0 until req_0 transfers with lock=0, then gnt_1 next cycle.
REQ-034 OWN1 entered, req_1 dropped -> IDLE next cycle, waiting req_0 granted following cycle.
REQ-035 Write 0xDEADBEEF byte_en 0b0011 addr 0x20 then read 0x20 -> mem_byte_en=0b0011 on write, rvalid with memory's data on read.
REQ-036 rst_n low mid-read (between transfer and response) -> rvalid_0 stays 0, state IDLE, next grant to requester 0.
